fifo_stream_reader: RTL

- Read-side consumer for the dual-clock FIFO. Sits entirely in the read clock domain.
- Pops words through the FIFO's rdEn/empty/rdData port and absorbs the RAM's 1-cycle registered read latency.
- Presents the data as a valid/ready stream, framing every BURST words with outLast.
- Also keeps a running count of words delivered, for debug and for the bench.

---
 rtl/fifo_stream_reader_pkg.sv | 11 +
 rtl/fifo_stream_reader_if.sv | 25 ++
 rtl/fifo_stream_reader_skid.sv | 52 +++++
 rtl/fifo_stream_reader.sv | 63 ++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO stream reader.
// Keeps beat-counter sizing in one place so the top and bench agree.
package fifo_stream_reader_pkg;

    localparam int BURST_MAX = 256;

    function automatic int beatWidth(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of the reader.
// master = the reader itself, slave = FIFO/downstream side.
interface fifo_stream_reader_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 fifoEmpty;
    logic                 fifoRdEn;
    logic [WIDTH-1:0]     fifoRdData;
    logic                 outValid;
    logic                 outReady;
    logic [WIDTH-1:0]     outData;
    logic                 outLast;
    logic [CNT_WIDTH-1:0] wordCnt;

    modport master (
        input  fifoEmpty, fifoRdData, outReady,
        output fifoRdEn, outValid, outData, outLast, wordCnt
    );

    modport slave (
        output fifoEmpty, fifoRdData, outReady,
        input  fifoRdEn, outValid, outData, outLast, wordCnt
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry register slice between the FIFO read data and the stream.
// head always presents the oldest word; tail only fills while head is stalled.
module fifo_stream_reader_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    input  logic             popOut,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            case ({inValid, popOut})
                2'b10: begin
                    if (occ == 2'd0) head <= inData;
                    else             tail <= inData;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves this cycle, so the new word lands behind whatever remains.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= inData;
                    end else begin
                        head <= inData;
                    end
                end
                default: ;
            endcase
        end
    end

    assign outValid = (occ != 2'd0);
    assign outData  = head;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain FIFO consumer: pops words, hides the 1-cycle RAM latency and
// emits a valid/ready stream framed every BURST words, with a delivered-word count.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BURST     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstN,
    fifo_stream_reader_if.master bus
);

    localparam int             BW        = beatWidth(BURST);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST - 1);

    logic                 inFlight;
    logic                 popOut;
    logic                 bufValid;
    logic [WIDTH-1:0]     bufData;
    logic [1:0]           occ;
    logic [2:0]           pending;
    logic [BW-1:0]        beat;
    logic [CNT_WIDTH-1:0] wordCntQ;

    fifo_stream_reader_skid #(.WIDTH(WIDTH)) skid (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inFlight),
        .inData   (bus.fifoRdData),
        .popOut   (popOut),
        .outValid (bufValid),
        .outData  (bufData),
        .occ      (occ)
    );

    assign popOut  = bufValid & bus.outReady;
    // Words held plus the one arriving, minus the one leaving, must stay below 2.
    assign pending = {1'b0, occ} + {2'b00, inFlight} - {2'b00, popOut};

    assign bus.fifoRdEn = rstN & ~bus.fifoEmpty & (pending < 3'd2);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inFlight <= 1'b0;
            beat     <= '0;
            wordCntQ <= '0;
        end else begin
            inFlight <= bus.fifoRdEn & ~bus.fifoEmpty;
            if (popOut) begin
                beat     <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
                wordCntQ <= wordCntQ + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.outValid = bufValid;
    assign bus.outData  = bufData;
    assign bus.outLast  = bufValid & (beat == LAST_BEAT);
    assign bus.wordCnt  = wordCntQ;

endmodule
